// File: rtl/adc_sample_buffer_pkg.sv
// Shared constants and helpers for the ADC sample buffer: EBI command codes,
// the ID word, the FIFO entry layout and the round-robin pick function.
package adc_buf_pkg;

  typedef enum logic [3:0] {
    CMD_NONE    = 4'h0,
    CMD_CONTROL = 4'h1,
    CMD_MASK    = 4'h2,
    CMD_DATA    = 4'h3,
    CMD_CHAN    = 4'h4,
    CMD_COUNT   = 4'h5,
    CMD_STATUS  = 4'h6,
    CMD_DROPS   = 4'h7,
    CMD_ID      = 4'h9
  } cmd_e;

  localparam logic [15:0] ID_VALUE  = 16'h5B0F;
  localparam int          ENTRY_W   = 19;
  localparam int          NUM_CHAN  = 8;

  typedef struct packed {
    logic [2:0]  chan;
    logic [15:0] data;
  } entry_t;

  // Round-robin pick: search req starting at last+1, wrapping 7 -> 0.
  // Returns {found, index}. Scanning downward lets the nearest hit win.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    rr_pick = '0;
    for (int k = 8; k >= 1; k--) begin
      idx = last + 3'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int k = 0; k < 8; k++) popcount8 = popcount8 + 4'(v[k]);
  endfunction

endpackage

// File: rtl/adc_sample_buffer_if.sv
// EBI register bus as seen by the sample buffer. The host side (master)
// drives address/data/strobes; the buffer (slave) returns registered read data.
// Handshake: an access is qualified whenever enable is high and the block
// select matches; wr commits on every qualified clock edge, re is level-held
// and data_out answers one clock after each qualified read edge.
interface adc_sample_buffer_if;
  logic [18:0] addr;
  logic [15:0] data_in;
  logic        enable;
  logic        re;
  logic        wr;
  logic [15:0] data_out;

  modport master (output addr, data_in, enable, re, wr, input data_out);
  modport slave  (input addr, data_in, enable, re, wr, output data_out);
endinterface

// File: rtl/adc_sample_buffer_fifo.sv
// Single-clock register FIFO with show-ahead head. Push on full and pop on
// empty are ignored; flush returns it to empty without touching storage.
module sample_fifo
  import adc_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [ENTRY_W-1:0]    din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [ENTRY_W-1:0]    head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  // Count can only reach DEPTH, so its top bit alone marks full.
  assign full   = r_count[DEPTH_LOG2];
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  // Pointer and occupancy tracking; flush has priority over push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/adc_sample_buffer.sv
// ADC sample buffer: captures per-channel sample updates into pending slots,
// arbitrates them round-robin into a tagged FIFO and exposes the FIFO plus
// control/status registers on the EBI register bus.
module adc_sample_buffer
  import adc_buf_pkg::*;
#(
  parameter int POSITION   = 0,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  adc_sample_buffer_if.slave   bus,
  input  logic [7:0]           sample_strobe,
  input  logic [127:0]         sample_data
);

  cmd_e                w_cmd;
  logic                w_sel;
  logic                w_rd;
  logic                w_wr;
  logic                w_data_rd;
  logic                w_pop;
  logic                w_flush;
  logic                w_ovf_clr;
  logic                w_drops_clr;
  logic [7:0]          w_cap;
  logic [3:0]          w_pick;
  logic [2:0]          w_gidx;
  logic                w_grant;
  logic [7:0]          w_gvec;
  logic [7:0]          w_drop_vec;
  logic [3:0]          w_drop_n;
  logic [15:0]         w_drop_base;
  logic [16:0]         w_drop_sum;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;
  logic [ENTRY_W-1:0]  w_fifo_head;
  entry_t              w_head;
  entry_t              w_push_entry;
  logic [15:0]         w_rd_val;
  logic                w_unused;

  logic                r_capture_en;
  logic [7:0]          r_mask;
  logic                r_ovf;
  logic [15:0]         r_drops;
  logic [7:0]          r_pend;
  logic [15:0]         r_pend_data [NUM_CHAN];
  logic [2:0]          r_last_grant;
  logic                r_data_rd_d;
  logic [15:0]         r_data_out;

  // Bus decode and write-side strobes.
  assign w_cmd       = cmd_e'(bus.addr[3:0]);
  assign w_sel       = bus.enable & (bus.addr[18:8] == 11'(POSITION));
  assign w_rd        = w_sel & bus.re;
  assign w_wr        = w_sel & bus.wr;
  assign w_data_rd   = w_rd & (w_cmd == CMD_DATA);
  assign w_pop       = w_data_rd & ~r_data_rd_d & ~w_empty;
  assign w_flush     = w_wr & (w_cmd == CMD_CONTROL) & bus.data_in[1];
  assign w_ovf_clr   = w_wr & (w_cmd == CMD_STATUS) & bus.data_in[2];
  assign w_drops_clr = w_wr & (w_cmd == CMD_DROPS);
  assign w_unused    = ^{bus.addr[7:4], bus.data_in[15:8]};

  // Capture qualification; a strobe in the flush cycle is discarded.
  assign w_cap = (r_capture_en & ~w_flush) ? (r_mask & sample_strobe) : 8'h00;

  // Arbitration: one grant per cycle, held off while the FIFO is full or flushing.
  assign w_pick       = rr_pick(r_pend, r_last_grant);
  assign w_gidx       = w_pick[2:0];
  assign w_grant      = w_pick[3] & ~w_full & ~w_flush;
  assign w_gvec       = w_grant ? (8'h01 << w_gidx) : 8'h00;
  assign w_push_entry = '{chan: w_gidx, data: r_pend_data[w_gidx]};

  // A drop is a new capture landing on a pending slot that is not leaving this cycle.
  assign w_drop_vec  = w_cap & r_pend & ~w_gvec;
  assign w_drop_n    = popcount8(w_drop_vec);
  // A clear and new drops in one cycle keep the new drops.
  assign w_drop_base = w_drops_clr ? 16'h0000 : r_drops;
  assign w_drop_sum  = {1'b0, w_drop_base} + 17'(w_drop_n);

  sample_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_grant),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_push_entry),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_fifo_head)
  );

  assign w_head = entry_t'(w_fifo_head);

  // Pending slots: capture sets (and refreshes data), grant clears, flush empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      for (int i = 0; i < NUM_CHAN; i++) r_pend_data[i] <= '0;
    end else if (w_flush) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (w_cap[i]) begin
          r_pend[i]      <= 1'b1;
          r_pend_data[i] <= sample_data[16*i +: 16];
        end else if (w_gvec[i]) begin
          r_pend[i]      <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer; 7 makes the next search start at channel 0.
  always_ff @(posedge clk) begin
    if (reset || w_flush) r_last_grant <= 3'd7;
    else if (w_grant)     r_last_grant <= w_gidx;
  end

  // Control and mask registers written from the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_capture_en <= 1'b0;
      r_mask       <= 8'h00;
    end else if (w_wr) begin
      if (w_cmd == CMD_CONTROL) r_capture_en <= bus.data_in[0];
      if (w_cmd == CMD_MASK)    r_mask       <= bus.data_in[7:0];
    end
  end

  // Overflow flag and saturating drop counter; a new drop beats an ovf clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf   <= 1'b0;
      r_drops <= 16'h0000;
    end else begin
      if (w_drop_n != 4'd0) r_ovf <= 1'b1;
      else if (w_ovf_clr)   r_ovf <= 1'b0;
      r_drops <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  // Read data selection for the addressed register.
  always_comb begin
    w_rd_val = 16'h0000;
    case (w_cmd)
      CMD_CONTROL: w_rd_val = {15'h0, r_capture_en};
      CMD_MASK:    w_rd_val = {8'h00, r_mask};
      CMD_DATA:    w_rd_val = w_empty ? 16'h0000 : w_head.data;
      CMD_CHAN:    w_rd_val = w_empty ? 16'h0000 : {13'h0, w_head.chan};
      CMD_COUNT:   w_rd_val = 16'(w_count);
      CMD_STATUS:  w_rd_val = {12'h0, r_capture_en, r_ovf, w_full, w_empty};
      CMD_DROPS:   w_rd_val = r_drops;
      CMD_ID:      w_rd_val = ID_VALUE;
      default:     w_rd_val = 16'h0000;
    endcase
  end

  // Registered read port plus the DATA-read history used to pop only once per hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out  <= 16'h0000;
      r_data_rd_d <= 1'b0;
    end else begin
      r_data_out  <= w_rd ? w_rd_val : 16'h0000;
      r_data_rd_d <= w_data_rd;
    end
  end

  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer: a deep instance (256 entries) for the
// data path, arbitration, overwrite and flush, and a 4-entry instance for
// backpressure and drop counting.
module tb_adc_sample_buffer;
  import adc_buf_pkg::*;

  localparam logic [10:0] POS = 11'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   ss_a, ss_b;
  logic [127:0] sd_a, sd_b;
  int           total = 0;
  int           bad   = 0;
  logic [15:0]  val;

  adc_sample_buffer_if bus_a ();
  adc_sample_buffer_if bus_b ();

  adc_sample_buffer #(.POSITION(3), .DEPTH_LOG2(8)) u_big (
    .clk(clk), .reset(reset), .bus(bus_a), .sample_strobe(ss_a), .sample_data(sd_a));

  adc_sample_buffer #(.POSITION(3), .DEPTH_LOG2(2)) u_small (
    .clk(clk), .reset(reset), .bus(bus_b), .sample_strobe(ss_b), .sample_data(sd_b));

  // Clock
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [15:0] base);
    for (int i = 0; i < 8; i++) mk[16*i +: 16] = base + 16'(i);
  endfunction

  task automatic drive(input bit b, input logic en, input logic [10:0] blk, input logic [3:0] cmd,
                       input logic [15:0] wdata, input logic rd, input logic wrt);
    if (b) begin
      bus_b.enable = en; bus_b.addr = {blk, 4'h0, cmd}; bus_b.data_in = wdata;
      bus_b.re = rd; bus_b.wr = wrt;
    end else begin
      bus_a.enable = en; bus_a.addr = {blk, 4'h0, cmd}; bus_a.data_in = wdata;
      bus_a.re = rd; bus_a.wr = wrt;
    end
  endtask

  task automatic idle(input bit b);
    drive(b, 1'b0, 11'd0, 4'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic ebi_write(input bit b, input logic [3:0] cmd, input logic [15:0] wdata);
    @(negedge clk);
    drive(b, 1'b1, POS, cmd, wdata, 1'b0, 1'b1);
    @(negedge clk);
    idle(b);
  endtask

  task automatic ebi_read_blk(input bit b, input logic [10:0] blk, input logic [3:0] cmd,
                              output logic [15:0] rv);
    @(negedge clk);
    drive(b, 1'b1, blk, cmd, 16'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rv = b ? bus_b.data_out : bus_a.data_out;
    @(negedge clk);
    idle(b);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input bit b, input logic [3:0] cmd, input logic [15:0] exp, input string tag);
    logic [15:0] rv;
    ebi_read_blk(b, POS, cmd, rv);
    check(tag, rv, exp);
  endtask

  task automatic pulse(input bit b, input logic [7:0] strobes, input logic [15:0] base);
    @(negedge clk);
    if (b) begin ss_b = strobes; sd_b = mk(base); end
    else   begin ss_a = strobes; sd_a = mk(base); end
    @(negedge clk);
    if (b) ss_b = 8'h00; else ss_a = 8'h00;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    ss_a = '0; ss_b = '0; sd_a = '0; sd_b = '0;
    idle(1'b0); idle(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_dout_a", bus_a.data_out, 16'h0000);
    check("rst_dout_b", bus_b.data_out, 16'h0000);

    // Register defaults
    rd_chk(0, CMD_ID,     16'h5B0F, "id");
    rd_chk(0, CMD_STATUS, 16'h0001, "rst_status");
    rd_chk(0, CMD_COUNT,  16'h0000, "rst_count");
    rd_chk(0, CMD_DROPS,  16'h0000, "rst_drops");
    rd_chk(0, CMD_MASK,   16'h0000, "rst_mask");
    rd_chk(0, 4'h8,       16'h0000, "unused_cmd");
    ebi_read_blk(0, 11'd5, CMD_ID, val);
    check("other_block", val, 16'h0000);

    // All eight channels at once drain in order 0..7
    ebi_write(0, CMD_MASK, 16'h00FF);
    ebi_write(0, CMD_CONTROL, 16'h0001);
    rd_chk(0, CMD_CONTROL, 16'h0001, "ctrl_rb");
    pulse(0, 8'hFF, 16'h1000);
    wait_cycles(10);
    rd_chk(0, CMD_COUNT,  16'h0008, "burst_count");
    rd_chk(0, CMD_STATUS, 16'h0008, "burst_status");
    for (int i = 0; i < 8; i++) begin
      rd_chk(0, CMD_CHAN, 16'(i), $sformatf("burst_chan%0d", i));
      rd_chk(0, CMD_DATA, 16'h1000 + 16'(i), $sformatf("burst_data%0d", i));
    end
    rd_chk(0, CMD_STATUS, 16'h0009, "burst_empty");

    // Held DATA read pops once
    pulse(0, 8'h06, 16'h2000);
    wait_cycles(4);
    rd_chk(0, CMD_COUNT, 16'h0002, "hold_count2");
    @(negedge clk);
    drive(0, 1'b1, POS, CMD_DATA, 16'h0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1 if (j == 0) val = bus_a.data_out;
    end
    @(negedge clk);
    idle(0);
    check("hold_data", val, 16'h2001);
    rd_chk(0, CMD_COUNT, 16'h0001, "hold_count1");
    rd_chk(0, CMD_DATA,  16'h2002, "hold_next");
    rd_chk(0, CMD_DATA,  16'h0000, "empty_read");
    rd_chk(0, CMD_COUNT, 16'h0000, "empty_count");

    // Mask filters channel 0, keeps channel 2
    ebi_write(0, CMD_MASK, 16'h0004);
    for (int k = 0; k < 3; k++) pulse(0, 8'h05, 16'h3000 + 16'(k * 256));
    wait_cycles(4);
    rd_chk(0, CMD_COUNT, 16'h0003, "mask_count");
    for (int k = 0; k < 3; k++) begin
      rd_chk(0, CMD_CHAN, 16'h0002, $sformatf("mask_chan%0d", k));
      rd_chk(0, CMD_DATA, 16'h3002 + 16'(k * 256), $sformatf("mask_data%0d", k));
    end

    // Back-to-back strobes on all channels: seven overwrites, channel 3 (granted) keeps both
    ebi_write(0, CMD_MASK, 16'h00FF);
    @(negedge clk);
    ss_a = 8'hFF; sd_a = mk(16'h4000);
    @(negedge clk);
    sd_a = mk(16'h4100);
    @(negedge clk);
    ss_a = 8'h00;
    wait_cycles(12);
    rd_chk(0, CMD_COUNT,  16'h0009, "ovw_count");
    rd_chk(0, CMD_DROPS,  16'h0007, "ovw_drops");
    rd_chk(0, CMD_STATUS, 16'h000C, "ovw_status");
    rd_chk(0, CMD_CHAN,   16'h0003, "ovw_chan_first");
    rd_chk(0, CMD_DATA,   16'h4003, "ovw_data_first");
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] ch;
      ch = 3'(3 + k);
      rd_chk(0, CMD_CHAN, 16'(ch), $sformatf("ovw_chan%0d", k));
      rd_chk(0, CMD_DATA, 16'h4100 + 16'(ch), $sformatf("ovw_data%0d", k));
    end

    // Flush with 5 queued and 3 pending, plus a strobe in the flush cycle
    pulse(0, 8'h1F, 16'h5000);
    wait_cycles(8);
    rd_chk(0, CMD_COUNT, 16'h0005, "pre_flush_count");
    @(negedge clk);
    ss_a = 8'hE0; sd_a = mk(16'h5100);
    @(negedge clk);
    ss_a = 8'h01; sd_a = mk(16'h5200);
    drive(0, 1'b1, POS, CMD_CONTROL, 16'h0003, 1'b0, 1'b1);
    @(negedge clk);
    ss_a = 8'h00;
    idle(0);
    rd_chk(0, CMD_COUNT,  16'h0000, "flush_count_now");
    wait_cycles(4);
    rd_chk(0, CMD_COUNT,  16'h0000, "flush_count_later");
    rd_chk(0, CMD_STATUS, 16'h000D, "flush_status");
    rd_chk(0, CMD_DROPS,  16'h0007, "flush_drops");
    rd_chk(0, CMD_MASK,   16'h00FF, "flush_mask");
    // Arbiter restarts from channel 0 after flush
    pulse(0, 8'h24, 16'h6000);
    wait_cycles(4);
    rd_chk(0, CMD_CHAN, 16'h0002, "post_flush_chan0");
    rd_chk(0, CMD_DATA, 16'h6002, "post_flush_data0");
    rd_chk(0, CMD_CHAN, 16'h0005, "post_flush_chan1");
    rd_chk(0, CMD_DATA, 16'h6005, "post_flush_data1");
    ebi_write(0, CMD_STATUS, 16'h0004);
    rd_chk(0, CMD_STATUS, 16'h0009, "ovf_clear_a");
    ebi_write(0, CMD_DROPS, 16'h0000);
    rd_chk(0, CMD_DROPS, 16'h0000, "drops_clear_a");

    // Small FIFO: continuous strobes on channel 3, no reads
    ebi_write(1, CMD_MASK, 16'h0008);
    ebi_write(1, CMD_CONTROL, 16'h0001);
    rd_chk(1, CMD_MASK, 16'h0008, "small_mask");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ss_b = 8'h08; sd_b = mk(16'h7000 + 16'(k * 16));
    end
    @(negedge clk);
    ss_b = 8'h00;
    ebi_write(1, CMD_CONTROL, 16'h0000);
    rd_chk(1, CMD_COUNT,  16'h0004, "full_count");
    rd_chk(1, CMD_STATUS, 16'h0006, "full_status");
    rd_chk(1, CMD_DROPS,  16'h0003, "full_drops");
    rd_chk(1, CMD_DATA,   16'h7003, "full_pop0");
    rd_chk(1, CMD_COUNT,  16'h0004, "refill_count");
    rd_chk(1, CMD_DATA,   16'h7013, "full_pop1");
    rd_chk(1, CMD_DATA,   16'h7023, "full_pop2");
    rd_chk(1, CMD_DATA,   16'h7033, "full_pop3");
    rd_chk(1, CMD_DATA,   16'h7073, "held_pending");
    rd_chk(1, CMD_STATUS, 16'h0005, "drained_status");
    ebi_write(1, CMD_STATUS, 16'h0004);
    rd_chk(1, CMD_STATUS, 16'h0001, "ovf_clear_b");
    rd_chk(1, CMD_DROPS,  16'h0003, "drops_kept_b");
    ebi_write(1, CMD_DROPS, 16'h1234);
    rd_chk(1, CMD_DROPS,  16'h0000, "drops_clear_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
